rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- Retire/commit controller at the head of the reorder buffer; the consumer end of the ROB push/pop interface.
- Each cycle it inspects the two-entry head pair (slot 0 older, slot 1 younger), decides whether the pair may retire, and pops it.
- Issues architectural register writes and raises a pipeline flush with a redirect PC on exception or branch mispredict, honouring the MIPS delay slot.
- Keeps a retired-instruction counter.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect PC on any committed exception.
- CNT_WIDTH, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rob_empty  in  1  ROB has no entries
- head_valid  in  2  slot i holds a real instruction (0 = bubble)
- head_done  in  2  slot i has completed execution (result written via CDB)
- head_rd  in  2x5  destination register; 0 = no write
- head_value  in  2x32  result value
- head_pc  in  2x32  instruction PC
- head_exc  in  2  slot i raised an exception
- head_mispredict  in  2  slot i is a mispredicted branch
- head_target  in  2x32  correct branch target
- pop  out  1  pop head pair this cycle (combinational)
- reg_we  out  2  register write enable per slot (registered)
- reg_waddr  out  2x5  register write address
- reg_wdata  out  2x32  register write data
- flush  out  1  flush all speculative state (registered, 1-cycle pulse)
- flush_pc  out  32  fetch redirect PC, valid when flush=1
- epc  out  32  PC of last excepting instruction (held)
- retired_count  out  CNT_WIDTH  retired-instruction count, wraps

Behaviour:
- Reset (synchronous, any state): state=RUN; reg_we=0, reg_waddr=0, reg_wdata=0, flush=0, flush_pc=0, epc=0, retired_count=0.
- States: RUN, WAIT_DS, FLUSH.
- ready = !rob_empty && (!head_valid[0] || head_done[0]) && (!head_valid[1] || head_done[1]).
- pop = ready && state!=FLUSH. The pair always pops atomically.
- Per-slot decisions are evaluated on the popping cycle. Register writes, flush, flush_pc, epc and the counter update take effect the following cycle. Latency is 1 clock.
- reg_we[i] = 1 only for committed slots with head_rd[i]!=0. With no pop, reg_we=0 next cycle.
- RUN, slot 0 exception:
  - No writes from either slot; epc<=head_pc[0]; flush with flush_pc=EXC_VECTOR; ->FLUSH.
  - Exception takes priority over mispredict on the same slot.
- RUN, slot 0 mispredict (no exc on slot 0):
  - Slot 0 commits; slot 1 is its delay slot.
  - If slot 1 has an exception: slot 1 does not write, epc<=head_pc[1], flush_pc=EXC_VECTOR.
  - Otherwise slot 1 commits and flush_pc=head_target[0].
  - ->FLUSH.
- RUN, slot 1 exception (slot 0 clean): slot 0 commits, slot 1 does not; epc<=head_pc[1]; flush_pc=EXC_VECTOR; ->FLUSH.
- RUN, slot 1 mispredict (no exceptions): both commit; latch head_target[1] internally; ->WAIT_DS; no flush yet.
- WAIT_DS, on the next pop:
  - Slot 0 is the delay slot. If clean, it commits and flush_pc=latched target. If it has an exception, no write, epc<=head_pc[0], flush_pc=EXC_VECTOR.
  - Slot 1 is wrong-path: always discarded, no write.
  - ->FLUSH.
- WAIT_DS, no pop: hold state and the latched target.
- FLUSH: flush=1 for exactly this one cycle; pop=0; reg_we=0; next state RUN.
- Bubbles (head_valid[i]=0) never write and never count.
- retired_count += number of committed slots (0, 1 or 2), modulo 2^CNT_WIDTH.
- Excepting slots are not counted; discarded wrong-path slots are not counted.
- flush_pc holds its last value when flush=0. epc changes only on a committed exception.
- Empty ROB in RUN or WAIT_DS: pop=0 and state holds.
- Head pair not ready: pop=0, no side effects.

Test Plan:
- Two clean pairs back-to-back (rd=3/4, 5/0) -> pop=1 both cycles. Writes appear 1 cycle later: reg_we=2'b11 with addr 3/4, then 2'b01 with addr 5. retired_count=4.
- head_done=2'b01 with head_valid=2'b11 -> pop=0, no writes; raise done[1] -> pop=1 that cycle, writes next cycle.
- Slot 0 exception at pc 0x8000_0010 -> next cycle flush=1, flush_pc=0xBFC0_0380, epc=0x8000_0010, reg_we=0, count unchanged. Following cycle pop=0 even if ready.
- Slot 0 mispredict, target 0x8000_0100, slot 1 clean rd=7 -> both write, flush=1 with flush_pc=0x8000_0100, count+=2.
- Slot 1 mispredict, target 0x8000_0200 -> both commit, no flush. Next pair: slot 0 rd=9 writes, slot 1 rd=10 discarded. flush_pc=0x8000_0200; count +2 then +1.
- Assert rst while in WAIT_DS -> state RUN, all outputs 0. The next pair retires normally with no stale flush.

Source files
------------

// File: rtl/rob_commit.sv
// Retire controller at the ROB head: pops the two-entry head pair, writes results,
// and raises a one-cycle flush on exceptions or branch mispredicts (MIPS delay slot).
module rob_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rob_empty,
  input  logic [1:0]                 head_valid,
  input  logic [1:0]                 head_done,
  input  logic [1:0][4:0]            head_rd,
  input  logic [1:0][31:0]           head_value,
  input  logic [1:0][31:0]           head_pc,
  input  logic [1:0]                 head_exc,
  input  logic [1:0]                 head_mispredict,
  input  logic [1:0][31:0]           head_target,
  output logic                       pop,
  output logic [1:0]                 reg_we,
  output logic [1:0][4:0]            reg_waddr,
  output logic [1:0][31:0]           reg_wdata,
  output logic                       flush,
  output logic [31:0]                flush_pc,
  output logic [31:0]                epc,
  output logic [CNT_WIDTH-1:0]       retired_count
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_WAIT_DS = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [31:0]          target_q, target_d;
  logic [1:0]           reg_we_q, reg_we_d;
  logic [1:0][4:0]      reg_waddr_q, reg_waddr_d;
  logic [1:0][31:0]     reg_wdata_q, reg_wdata_d;
  logic                 flush_q, flush_d;
  logic [31:0]          flush_pc_q, flush_pc_d;
  logic [31:0]          epc_q, epc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic       ready;
  logic [1:0] exc, mis, commit, commit_eff;

  always_comb begin
    // Exception/mispredict flags only mean something on real instructions.
    exc   = head_exc & head_valid;
    mis   = head_mispredict & head_valid;
    ready = !rob_empty && (!head_valid[0] || head_done[0]) && (!head_valid[1] || head_done[1]);
    pop   = ready && (state_q != ST_FLUSH);

    state_d    = state_q;
    target_d   = target_q;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;
    epc_d      = epc_q;
    commit     = 2'b00;

    case (state_q)
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      ST_WAIT_DS: begin
        // Slot 0 is the delay slot of the earlier branch; slot 1 is wrong-path.
        if (pop) begin
          flush_d = 1'b1;
          state_d = ST_FLUSH;
          if (exc[0]) begin
            epc_d      = head_pc[0];
            flush_pc_d = EXC_VECTOR;
          end else begin
            commit[0]  = 1'b1;
            flush_pc_d = target_q;
          end
        end
      end
      default: begin
        if (pop) begin
          if (exc[0]) begin
            epc_d      = head_pc[0];
            flush_pc_d = EXC_VECTOR;
            flush_d    = 1'b1;
            state_d    = ST_FLUSH;
          end else if (mis[0]) begin
            commit[0] = 1'b1;
            flush_d   = 1'b1;
            state_d   = ST_FLUSH;
            if (exc[1]) begin
              epc_d      = head_pc[1];
              flush_pc_d = EXC_VECTOR;
            end else begin
              commit[1]  = 1'b1;
              flush_pc_d = head_target[0];
            end
          end else if (exc[1]) begin
            commit[0]  = 1'b1;
            epc_d      = head_pc[1];
            flush_pc_d = EXC_VECTOR;
            flush_d    = 1'b1;
            state_d    = ST_FLUSH;
          end else if (mis[1]) begin
            commit   = 2'b11;
            target_d = head_target[1];
            state_d  = ST_WAIT_DS;
          end else begin
            commit = 2'b11;
          end
        end
      end
    endcase

    commit_eff  = commit & head_valid;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    for (int i = 0; i < 2; i++) begin
      reg_we_d[i] = commit_eff[i] && (head_rd[i] != 5'd0);
      if (reg_we_d[i]) begin
        reg_waddr_d[i] = head_rd[i];
        reg_wdata_d[i] = head_value[i];
      end
    end
    count_d = count_q + CNT_WIDTH'(commit_eff[0]) + CNT_WIDTH'(commit_eff[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      target_q    <= '0;
      reg_we_q    <= '0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      flush_q     <= 1'b0;
      flush_pc_q  <= '0;
      epc_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      flush_q     <= flush_d;
      flush_pc_q  <= flush_pc_d;
      epc_q       <= epc_d;
      count_q     <= count_d;
    end
  end

  assign reg_we        = reg_we_q;
  assign reg_waddr     = reg_waddr_q;
  assign reg_wdata     = reg_wdata_q;
  assign flush         = flush_q;
  assign flush_pc      = flush_pc_q;
  assign epc           = epc_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_rob_commit.sv
// Directed plus random stimulus for rob_commit, checked against a retire-order
// reference model that walks the head pair instruction by instruction.
module tb_rob_commit;

  logic             clk = 1'b0;
  logic             rst;
  logic             rob_empty;
  logic [1:0]       head_valid, head_done, head_exc, head_mispredict;
  logic [1:0][4:0]  head_rd;
  logic [1:0][31:0] head_value, head_pc, head_target;
  logic             pop;
  logic [1:0]       reg_we;
  logic [1:0][4:0]  reg_waddr;
  logic [1:0][31:0] reg_wdata;
  logic             flush;
  logic [31:0]      flush_pc, epc, retired_count;

  rob_commit #(.EXC_VECTOR(32'hBFC0_0380), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rob_empty(rob_empty),
    .head_valid(head_valid), .head_done(head_done), .head_rd(head_rd),
    .head_value(head_value), .head_pc(head_pc), .head_exc(head_exc),
    .head_mispredict(head_mispredict), .head_target(head_target),
    .pop(pop), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .flush(flush), .flush_pc(flush_pc), .epc(epc), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending delay slot, flushing cycle, and expected outputs.
  bit          m_pending_ds, m_flushing;
  logic [31:0] m_ds_target;
  logic [1:0]  exp_we;
  logic [4:0]  exp_waddr [2];
  logic [31:0] exp_wdata [2];
  logic        exp_flush;
  logic [31:0] exp_fpc, exp_epc, exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending_ds = 0; m_flushing = 0; m_ds_target = '0;
    exp_we = '0; exp_flush = 0; exp_fpc = '0; exp_epc = '0; exp_cnt = '0;
    for (int i = 0; i < 2; i++) begin exp_waddr[i] = '0; exp_wdata[i] = '0; end
  endtask

  function automatic bit model_pop();
    bit rdy;
    rdy = !rob_empty && (!head_valid[0] || head_done[0]) && (!head_valid[1] || head_done[1]);
    return rdy && !m_flushing;
  endfunction

  task automatic retire(input int i);
    if (head_valid[i]) begin
      exp_cnt++;
      if (head_rd[i] != 0) begin
        exp_we[i] = 1'b1; exp_waddr[i] = head_rd[i]; exp_wdata[i] = head_value[i];
      end
    end
  endtask

  task automatic take_exc(input int i);
    exp_epc = head_pc[i]; exp_fpc = 32'hBFC0_0380; exp_flush = 1'b1;
  endtask

  task automatic model_step();
    bit p, stop;
    p = model_pop();
    exp_we = '0; exp_flush = 0;
    if (m_flushing) m_flushing = 0;
    else if (p) begin
      if (m_pending_ds) begin
        m_pending_ds = 0;
        if (head_valid[0] && head_exc[0]) take_exc(0);
        else begin retire(0); exp_fpc = m_ds_target; exp_flush = 1; end
      end else begin
        stop = 0;
        for (int i = 0; i < 2 && !stop; i++) begin
          if (head_valid[i] && head_exc[i]) begin take_exc(i); stop = 1; end
          else begin
            retire(i);
            if (head_valid[i] && head_mispredict[i]) begin
              stop = 1;
              if (i == 1) begin m_pending_ds = 1; m_ds_target = head_target[1]; end
              else if (head_valid[1] && head_exc[1]) take_exc(1);
              else begin retire(1); exp_fpc = head_target[0]; exp_flush = 1; end
            end
          end
        end
      end
      if (exp_flush) m_flushing = 1;
    end
  endtask

  task automatic check_outputs(input string step);
    chk({step, ".reg_we"}, 32'(reg_we), 32'(exp_we));
    for (int i = 0; i < 2; i++) if (exp_we[i]) begin
      chk($sformatf("%s.waddr%0d", step, i), 32'(reg_waddr[i]), 32'(exp_waddr[i]));
      chk($sformatf("%s.wdata%0d", step, i), reg_wdata[i], exp_wdata[i]);
    end
    chk({step, ".flush"}, 32'(flush), 32'(exp_flush));
    chk({step, ".flush_pc"}, flush_pc, exp_fpc);
    chk({step, ".epc"}, epc, exp_epc);
    chk({step, ".count"}, retired_count, exp_cnt);
  endtask

  // One clock: check combinational pop, advance model, check registered outputs.
  task automatic cycle(input string step);
    #1;
    chk({step, ".pop"}, 32'(pop), 32'(model_pop()));
    model_step();
    @(posedge clk); #1;
    check_outputs(step);
    $display("step %-10s pop=%0d we=%b flush=%0d fpc=%h epc=%h cnt=%0d",
             step, pop, reg_we, flush, flush_pc, epc, retired_count);
  endtask

  task automatic drive(input logic empty, input logic [1:0] v, d, e, m,
                       input logic [4:0] r0, r1, input logic [31:0] pc0, tgt);
    rob_empty = empty; head_valid = v; head_done = d; head_exc = e; head_mispredict = m;
    head_rd[0] = r0; head_rd[1] = r1;
    head_pc[0] = pc0; head_pc[1] = pc0 + 32'd4;
    head_value[0] = $urandom; head_value[1] = $urandom;
    head_target[0] = tgt; head_target[1] = tgt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    drive(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0);
    do_reset();
    check_outputs("reset");

    // Two clean pairs back to back.
    drive(0, 2'b11, 2'b11, 2'b00, 2'b00, 3, 4, 32'h8000_0000, 32'h0);
    cycle("clean1");
    drive(0, 2'b11, 2'b11, 2'b00, 2'b00, 5, 0, 32'h8000_0008, 32'h0);
    cycle("clean2");
    chk("clean2.count4", retired_count, 32'd4);

    // Not ready, then ready.
    drive(0, 2'b11, 2'b01, 2'b00, 2'b00, 11, 12, 32'h8000_0010, 32'h0);
    cycle("notready");
    head_done = 2'b11;
    cycle("nowready");

    // Slot 0 exception, then a ready pair during the flush cycle.
    drive(0, 2'b11, 2'b11, 2'b01, 2'b00, 13, 14, 32'h8000_0010, 32'h0);
    cycle("exc0");
    chk("exc0.epc", epc, 32'h8000_0010);
    drive(0, 2'b11, 2'b11, 2'b00, 2'b00, 15, 16, 32'h8000_0020, 32'h0);
    cycle("flushhold");
    cycle("afterflush");

    // Slot 0 mispredict with clean delay slot.
    drive(0, 2'b11, 2'b11, 2'b00, 2'b01, 6, 7, 32'h8000_0030, 32'h8000_0100);
    cycle("mis0");
    chk("mis0.fpc", flush_pc, 32'h8000_0100);
    drive(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0);
    cycle("mis0.fl");

    // Slot 1 mispredict: delay slot arrives in the following pair.
    drive(0, 2'b11, 2'b11, 2'b00, 2'b10, 1, 2, 32'h8000_0040, 32'h8000_0200);
    cycle("mis1");
    drive(0, 2'b11, 2'b11, 2'b00, 2'b00, 9, 10, 32'h8000_0048, 32'h0);
    cycle("ds");
    chk("ds.fpc", flush_pc, 32'h8000_0200);
    drive(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0);
    cycle("ds.fl");

    // Reset while waiting for a delay slot.
    drive(0, 2'b11, 2'b11, 2'b00, 2'b10, 17, 18, 32'h8000_0060, 32'h8000_0300);
    cycle("mis1b");
    drive(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0);
    do_reset();
    check_outputs("rst_wds");
    drive(0, 2'b11, 2'b11, 2'b00, 2'b00, 19, 20, 32'h8000_0070, 32'h0);
    cycle("postrst");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [1:0] v, d, e, m;
      logic [4:0] r0, r1;
      v = 2'($urandom);
      d = 2'($urandom) | 2'($urandom);
      e = v & 2'($urandom) & 2'($urandom) & 2'($urandom);
      m = v & 2'($urandom) & 2'($urandom);
      r0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      drive($urandom_range(0, 5) == 0, v, d, e, m, r0, r1,
            {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
